// File: rtl/shuffle_nonce_arbiter.sv
// Round-robin arbiter sharing one nonce output register between NUM_REQ
// shuffle FIFO unloaders. Each unloader uses a 4-phase req/ack handshake.
//
// state    | meaning
// ST_IDLE  | no handshake open; grant when a request is pending and the slot is free
// ST_ACK   | ack raised to gnt_q; waiting for that requester to drop req
module shuffle_nonce_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int nonce_width = 7,
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*nonce_width-1:0] i_data,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic [nonce_width-1:0]         o_data,
  output logic [ID_WIDTH-1:0]            o_grant_id,
  output logic                           o_valid,
  input  logic                           i_ready
);

  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     req_q;
  logic [ID_WIDTH-1:0]    last_q, last_d;
  logic [ID_WIDTH-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [nonce_width-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]    gid_q, gid_d;
  logic                   valid_q, valid_d;

  logic                   win_found;
  logic [ID_WIDTH-1:0]    win_idx;
  logic                   slot_free;
  logic                   grant;

  // Round-robin winner search starting just after the last completed requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(last_q) + i) % NUM_REQ;
      if (!win_found && req_q[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_WIDTH'(idx);
      end
    end
  end

  assign slot_free = !valid_q || i_ready;
  assign grant     = (state_q == ST_IDLE) && win_found && slot_free;

  // Next-state, handshake and output-register update
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    data_d  = data_q;
    gid_d   = gid_q;
    valid_d = valid_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          data_d         = i_data[int'(win_idx)*nonce_width +: nonce_width];
          gid_d          = win_idx;
          valid_d        = 1'b1;
          ack_d[win_idx] = 1'b1;
          gnt_d          = win_idx;
          state_d        = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_q[gnt_q]) begin
          ack_d[gnt_q] = 1'b0;
          last_d       = gnt_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any open handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      last_q  <= ID_WIDTH'(NUM_REQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= i_req;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      valid_q <= valid_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_data     = data_q;
  assign o_grant_id = gid_q;
  assign o_valid    = valid_q;

endmodule

// File: tb/tb_shuffle_nonce_arbiter.sv
// Directed bench for shuffle_nonce_arbiter (NUM_REQ=4, nonce_width=7).
module tb_shuffle_nonce_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_req;
  logic [27:0] i_data;
  logic [3:0]  o_ack;
  logic [6:0]  o_data;
  logic [1:0]  o_grant_id;
  logic        o_valid;
  logic        i_ready;

  int checks = 0;
  int fails  = 0;
  int xfers  = 0;
  int ng     = 0;
  int bad    = 0;
  logic [1:0] rr_gid [6];
  logic [6:0] rr_dat [6];

  shuffle_nonce_arbiter #(.NUM_REQ(4), .nonce_width(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_data     (o_data),
    .o_grant_id (o_grant_id),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // counts a transfer when valid && ready are presented to the coming edge
  task automatic tick();
    if (o_valid && i_ready) xfers++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [6:0] v);
    i_data[k*7 +: 7] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  // 4-phase requester behaviour: drop on ack, re-raise once ack is low again
  task automatic model_step(input logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        if (i_req[k] && o_ack[k]) i_req[k] = 1'b0;
        else if (!i_req[k] && !o_ack[k]) i_req[k] = 1'b1;
      end
    end
  endtask

  // ack must never be multi-hot
  always @(negedge clk) check("ack_onehot", 32'($onehot0(o_ack)), 32'd1);

  initial begin
    rst_n   = 1'b0;
    i_req   = 4'b0000;
    i_data  = '0;
    i_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ack",   32'(o_ack),   32'd0);
    check("rst_data",  32'(o_data),  32'd0);
    check("rst_gid",   32'(o_grant_id), 32'd0);
    rst_n = 1'b1;

    // single request on lane 2
    set_lane(2, 7'h35);
    i_req = 4'b0100;
    tick();
    check("single_latency", 32'(o_valid), 32'd0);
    tick();
    check("single_valid", 32'(o_valid), 32'd1);
    check("single_data",  32'(o_data),  32'h35);
    check("single_gid",   32'(o_grant_id), 32'd2);
    check("single_ack",   32'(o_ack),   32'b0100);
    i_req = 4'b0000;
    tick();
    check("single_ack_hold", 32'(o_ack), 32'b0100);
    check("single_xfer",     32'(o_valid), 32'd0);
    tick();
    check("single_ack_drop", 32'(o_ack), 32'd0);

    // round robin with all four requesting
    do_reset();
    for (int k = 0; k < 4; k++) set_lane(k, 7'(8'h10 + k));
    i_req = 4'b1111;
    ng = 0;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      tick();
      if (o_valid) begin
        rr_gid[ng] = o_grant_id;
        rr_dat[ng] = o_data;
        ng++;
      end
      model_step(4'b1111);
    end
    check("rr_count", 32'(ng), 32'd6);
    for (int n = 0; n < 6; n++) begin
      check("rr_gid",  32'(rr_gid[n]), 32'(n % 4));
      check("rr_data", 32'(rr_dat[n]), 32'(8'h10 + (n % 4)));
    end
    i_req = 4'b0000;
    repeat (4) tick();

    // backpressure: lanes 1 and 3, downstream stalled
    do_reset();
    i_ready = 1'b0;
    set_lane(1, 7'h21);
    set_lane(3, 7'h23);
    i_req = 4'b1010;
    xfers = 0;
    tick();
    tick();
    check("bp_gid1",   32'(o_grant_id), 32'd1);
    check("bp_data1",  32'(o_data),  32'h21);
    check("bp_ack1",   32'(o_ack),   32'b0010);
    check("bp_valid1", 32'(o_valid), 32'd1);
    i_req = 4'b1000;
    tick();
    tick();
    check("bp_ack1_drop", 32'(o_ack), 32'd0);
    repeat (3) tick();
    check("bp_wait_ack",   32'(o_ack),   32'd0);
    check("bp_wait_data",  32'(o_data),  32'h21);
    check("bp_wait_gid",   32'(o_grant_id), 32'd1);
    check("bp_wait_valid", 32'(o_valid), 32'd1);
    i_ready = 1'b1;
    tick();
    check("bp_gid3",   32'(o_grant_id), 32'd3);
    check("bp_data3",  32'(o_data),  32'h23);
    check("bp_ack3",   32'(o_ack),   32'b1000);
    check("bp_valid3", 32'(o_valid), 32'd1);
    i_req = 4'b0000;
    repeat (3) tick();
    check("bp_xfers", 32'(xfers), 32'd2);
    check("bp_idle_ack", 32'(o_ack), 32'd0);
    check("bp_idle_valid", 32'(o_valid), 32'd0);

    // back-to-back alternating lanes 0 and 2
    do_reset();
    i_ready = 1'b1;
    set_lane(0, 7'h40);
    set_lane(2, 7'h42);
    i_req = 4'b0101;
    xfers = 0;
    ng = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (o_valid) begin
        check("b2b_gid",  32'(o_grant_id), (ng % 2 == 1) ? 32'd2 : 32'd0);
        check("b2b_data", 32'(o_data), (ng % 2 == 1) ? 32'h42 : 32'h40);
        ng++;
      end
      model_step(4'b0101);
    end
    i_req = 4'b0000;
    repeat (6) begin
      tick();
      if (o_valid) ng++;
    end
    check("b2b_min_grants", 32'(ng >= 8), 32'd1);
    check("b2b_xfers", 32'(xfers), 32'(ng));

    // reset while in ACK with a valid entry held
    do_reset();
    i_ready = 1'b0;
    set_lane(0, 7'h5A);
    i_req = 4'b0001;
    tick();
    tick();
    check("rm_pre_ack",   32'(o_ack),   32'b0001);
    check("rm_pre_valid", 32'(o_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rm_valid", 32'(o_valid), 32'd0);
    check("rm_ack",   32'(o_ack),   32'd0);
    check("rm_data",  32'(o_data),  32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("rm_regrant_ack",  32'(o_ack),   32'b0001);
    check("rm_regrant_gid",  32'(o_grant_id), 32'd0);
    check("rm_regrant_data", 32'(o_data),  32'h5A);
    i_req = 4'b0000;
    i_ready = 1'b1;
    repeat (3) tick();

    // late drop: lane 2 pulses req while lane 1 is being served
    do_reset();
    i_ready = 1'b1;
    set_lane(1, 7'h51);
    set_lane(2, 7'h52);
    i_req = 4'b0010;
    tick();
    tick();
    check("ld_gid1", 32'(o_grant_id), 32'd1);
    check("ld_ack1", 32'(o_ack), 32'b0010);
    bad = 0;
    i_req = 4'b0110;
    tick();
    if (o_ack[2] || (o_valid && o_grant_id == 2'd2)) bad++;
    i_req = 4'b0010;
    tick();
    if (o_ack[2] || (o_valid && o_grant_id == 2'd2)) bad++;
    i_req = 4'b0000;
    repeat (8) begin
      tick();
      if (o_ack[2] || (o_valid && o_grant_id == 2'd2)) bad++;
    end
    check("ld_no_serve2", 32'(bad), 32'd0);
    check("ld_final_ack", 32'(o_ack), 32'd0);
    check("ld_final_gid", 32'(o_grant_id), 32'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/shuffle_nonce_arbiter.md
Name: shuffle_nonce_arbiter

Overview:
- Shares one downstream nonce consumer (the shuffle re-issue path) between NUM_REQ shuffle FIFO unloaders.
- Each unloader presents a nonce with a 4-phase level handshake (req/ack). The arbiter picks one requester round-robin, captures its nonce into a single output register with valid/ready, and completes that requester's 4-phase handshake.
- Sits between the per-lane unloaders and the nonce scheduler feeding the hash pipeline.

Parameters:
- NUM_REQ, 4, number of requesting unloaders; >= 2.
- nonce_width, 7, width of each nonce/thread ID.
- ID_WIDTH, $clog2(NUM_REQ), width of o_grant_id.

Ports:
- clk  input  1  single clock; everything is synchronous to its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- i_req  input  NUM_REQ  per-requester 4-phase request level; data is stable while high.
- i_data  input  NUM_REQ*nonce_width  packed nonces; requester k at bits [k*nonce_width +: nonce_width].
- o_ack  output  NUM_REQ  per-requester 4-phase acknowledge level.
- o_data  output  nonce_width  captured nonce.
- o_grant_id  output  ID_WIDTH  index of the requester that supplied o_data.
- o_valid  output  1  o_data/o_grant_id hold a valid entry.
- i_ready  input  1  downstream accepts; a transfer occurs when o_valid && i_ready.

Behaviour:
- Reset (rst_n=0 at an edge):
  - o_ack=0, o_valid=0, o_data=0, o_grant_id=0.
  - State=IDLE, req_q=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-handshake abandons that handshake. A requester still holding req after reset is served again as a new request; this is acceptable because the unloaders share the same reset.
- Input stage: req_q <= i_req every cycle, one register stage. All decisions use req_q. i_data is sampled directly at the grant edge.
- Slot free: slot_free = !o_valid || i_ready.
- FSM, two states:
  - IDLE, when (req_q != 0) && slot_free at an edge:
    - w = first set bit of req_q searching last+1, last+2, ... modulo NUM_REQ.
    - o_data <= i_data[w], o_grant_id <= w, o_valid <= 1, o_ack[w] <= 1, gnt <= w, state <= ACK.
    - Otherwise stay in IDLE.
  - ACK, when req_q[gnt]==0:
    - o_ack[gnt] <= 0, last <= gnt, state <= IDLE.
    - Otherwise hold o_ack[gnt]=1. Requests from other lanes wait.
- Output register:
  - If o_valid && i_ready and no new grant at the same edge, o_valid <= 0.
  - A grant at the same edge as a transfer loads the new entry; o_valid stays 1.
  - o_data and o_grant_id hold while o_valid && !i_ready.
- One-hot ack: at most one o_ack bit is high at any time. o_ack changes only in the two cases above.
- Latency:
  - i_req[k] rises at edge t with the arbiter idle and the slot free → req_q at t+1 → o_valid, o_ack[k] high after edge t+2.
  - i_req[k] falls → o_ack[k] falls 2 edges later.
  - Next grant no earlier than the edge after ACK→IDLE.
- Fairness: a requester that just completed is lowest priority on the next arbitration. With all NUM_REQ requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0,...
- Backpressure: a grant never overwrites an unaccepted entry. If i_ready=0 with o_valid=1, IDLE waits; pending requesters keep req high, and no ack is raised.
- A requester whose req falls before it is granted (protocol violation) is simply not served. No error flag.
- Widths: winner search covers exactly NUM_REQ bits; the pointer wraps modulo NUM_REQ. o_grant_id is zero-extended when NUM_REQ is not a power of two.

Test Plan:
- Single request: reset; i_req=4'b0100, i_data lane2=7'h35, i_ready=1.
  - Required: o_valid=1, o_data=7'h35, o_grant_id=2, o_ack=4'b0100 two cycles after req.
  - Drop i_req[2]: o_ack=0 two cycles later.
- Round-robin: requesters 0..3 hold req with nonces 7'h10..7'h13; each drops req on ack and re-raises one cycle later.
  - Required grant order 0,1,2,3,0,1 and o_data order 10,11,12,13,10,11.
- Backpressure: i_ready=0, requesters 1 and 3 active.
  - Requester 1 is captured and acked.
  - Requester 3 gets no ack, and o_data holds, until i_ready=1 for a cycle.
  - Then requester 3 is granted; exactly two transfers are observed.
- Back-to-back throughput: i_ready=1 held, two requesters alternating.
  - Each transfer observed exactly once.
  - o_ack is never multi-hot (assertion checked every cycle).
- Reset mid-operation: assert rst_n=0 while in ACK with o_valid=1, o_ack=4'b0001.
  - Next cycle: o_valid=0, o_ack=0.
  - With req0 still high after reset release: requester 0 is re-granted within 2 cycles.
- Late drop: requester 2 raises req then drops it before grant while requester 1 is being served.
  - Required: no ack to 2, o_grant_id never 2.
